uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Oversampling timing and bit-recovery stage of the UART receiver, directly upstream of the receive FSM. Counts oversampling edges and bit periods from the FSM's enables, takes three mid-bit samples of the synchronised serial line, and majority-votes them into one recovered bit. Supplies `bit_cnt`, `edge_cnt_max`, `take_sample`, `str_glitch` and `sampled_bit` to the FSM and the parity, start and stop checkers.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `RX_IN` synchroniser. 0 bypasses the synchroniser.
- `BIT_CNT_MAX`, 11: saturation value of `bit_cnt`.

Ports:
- `clk_RX` in 1: oversampling clock.
- `rst` in 1: asynchronous, active-low reset.
- `RX_IN` in 1: raw serial line, idle high.
- `Prescale` in 6: oversampling ratio. Legal values are 8, 16 and 32; any other value behaves as 8.
- `edge_cnt_enable` in 1: counters run when 1. When 0, counters clear synchronously.
- `dat_samp_en` in 1: sample capture enable.
- `edge_cnt` out 6: current edge index within the bit, 0..P-1.
- `bit_cnt` out 4: completed bit periods since the counters were enabled.
- `edge_cnt_max` out 1: high when `edge_cnt_enable` is 1 and `edge_cnt` = P-1 (combinational from registers).
- `sampled_bit` out 1: majority-vote result, registered.
- `take_sample` out 1: one-cycle strobe marking a new `sampled_bit`.
- `str_glitch` out 1: level flag, start-bit vote returned 1.

## Operation
- P is the effective prescale; H = P/2.
- `rx_s` is `RX_IN` after `SYNC_STAGES` flops. The synchroniser flops reset to 1.
- Edge counter:
  - When `edge_cnt_enable` is 0: `edge_cnt` and `bit_cnt` are 0 next cycle.
  - Otherwise `edge_cnt` increments each cycle.
  - At P-1, `edge_cnt` wraps to 0 and `bit_cnt` increments, saturating at `BIT_CNT_MAX`. There is no wrap to 0.
- Sampling, only while `dat_samp_en` and `edge_cnt_enable` are both 1:
  - Capture `rx_s` into s0, s1 and s2 at `edge_cnt` = H-1, H and H+1.
  - At `edge_cnt` = H+2: `sampled_bit` <= majority(s0, s1, s2), and `take_sample` = 1 for exactly that one cycle.
- With `dat_samp_en` = 0:
  - No captures and no `take_sample`.
  - `sampled_bit` holds.
  - A partial sample set is discarded; the next vote needs three fresh captures.
- Start glitch:
  - `str_glitch` sets to 1 when a vote completes with `bit_cnt` = 0 and result 1.
  - It clears when `edge_cnt_enable` = 0, or when a vote completes with `bit_cnt` = 0 and result 0.
  - It holds otherwise, so it is still valid when `bit_cnt` reaches 1.
- Prescale changes take effect immediately. They are legal only while `edge_cnt_enable` = 0.
  - If `Prescale` changes mid-frame and `edge_cnt` ≥ new P, the counter runs to 63, wraps, and `bit_cnt` increments once.
  - That frame is corrupt; no recovery is provided.

## Timing
- Reset values:
  - `edge_cnt` = 0, `bit_cnt` = 0, `edge_cnt_max` = 0.
  - `sampled_bit` = 1, `take_sample` = 0, `str_glitch` = 0.
  - s0, s1, s2 = 1; synchroniser = 1.
- Reset is asynchronous and may assert mid-frame. All state returns to reset values with no residual strobe.
- Enable timing: `edge_cnt_enable` rising at cycle 0 gives `edge_cnt` = 1 at cycle 1.
- `take_sample` occurs H+2 cycles after `edge_cnt` = 0.
  - Example, P = 8: samples at edges 3, 4 and 5; strobe at edge 6; `edge_cnt_max` at edge 7.
- Latency from `RX_IN` to the vote inputs is `SYNC_STAGES` cycles.
- `edge_cnt_max` and the `bit_cnt` increment refer to the same wrap event.
  - `edge_cnt_max` is high in the last cycle of a bit.
  - `bit_cnt` shows the new value on the following cycle.
- Simultaneous events:
  - Enable falling on the cycle of a wrap: the clear wins.
  - Enable falling on the cycle of H+2: the vote is not committed.

## Structure
- Package `uart_rx_pkg` holds:
  - `PRESCALE_8`, `PRESCALE_16`, `PRESCALE_32`.
  - Bit-count width and the frame-length constants shared with the receive FSM.
- Sub-module `bit_sync`: parameterised N-stage synchroniser with reset value 1.
- Counter, sampler and vote logic stay in this module.

## Test plan
- P = 8, `SYNC_STAGES` = 0, both enables held high, `RX_IN` driven 0 for one bit period then alternating 1/0 per period:
  - `take_sample` at edge 6 of every bit.
  - `sampled_bit` = 0, 1, 0, …
  - `edge_cnt_max` at edge 7.
  - `bit_cnt` counts 1..11, then stays 11.
- P = 16, start bit with `RX_IN` low only for edges 0–6 (high at samples 7, 8 and 9): vote = 1 and `str_glitch` = 1 by the time `bit_cnt` = 1.
- P = 32, one-edge glitch at sample edge 16 inside a 0 bit: majority gives `sampled_bit` = 0.
- Mid-bit drops:
  - Drop `dat_samp_en` at edge 4 (P = 8): no `take_sample` that bit; `sampled_bit` holds.
  - Drop `edge_cnt_enable` at edge 5: next cycle `edge_cnt` = 0, `bit_cnt` = 0, `str_glitch` = 0.
- Assert `rst` at `bit_cnt` = 5, edge 6: every output returns to its reset value with no strobe. `Prescale` = 20 behaves identically to P = 8.

Source files
------------

// File: rtl/uart_rx_sampler_pkg.sv
// uart_rx_pkg
// Shared constants and helpers for the UART receive path: the legal
// oversampling ratios, bit-count width, frame lengths used by the receive
// FSM, and the small pure functions used by the sampler.
package uart_rx_pkg;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int BIT_CNT_W = 4;

  // Frame length in bit periods: start + 8 data + stop, optionally + parity.
  localparam int FRAME_BITS_NO_PAR = 10;
  localparam int FRAME_BITS_PAR    = 11;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
  typedef logic [5:0]           edge_cnt_t;

  // Any prescale outside the supported set falls back to 8x oversampling.
  function automatic edge_cnt_t eff_prescale(input logic [5:0] p);
    edge_cnt_t r;
    case (p)
      PRESCALE_16: r = PRESCALE_16;
      PRESCALE_32: r = PRESCALE_32;
      default:     r = PRESCALE_8;
    endcase
    return r;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if
// Bundles the sampler's control inputs and recovered-bit outputs.
//   master : receive FSM / line side (drives RX_IN, Prescale, enables)
//   slave  : uart_rx_sampler (drives counters, strobe and recovered bit)
interface uart_rx_sampler_if;
  import uart_rx_pkg::*;

  logic      RX_IN;
  logic [5:0] Prescale;
  logic      edge_cnt_enable;
  logic      dat_samp_en;
  edge_cnt_t edge_cnt;
  bit_cnt_t  bit_cnt;
  logic      edge_cnt_max;
  logic      sampled_bit;
  logic      take_sample;
  logic      str_glitch;

  modport master (
    output RX_IN, Prescale, edge_cnt_enable, dat_samp_en,
    input  edge_cnt, bit_cnt, edge_cnt_max, sampled_bit, take_sample, str_glitch
  );

  modport slave (
    input  RX_IN, Prescale, edge_cnt_enable, dat_samp_en,
    output edge_cnt, bit_cnt, edge_cnt_max, sampled_bit, take_sample, str_glitch
  );

endinterface

// File: rtl/uart_rx_sampler_bit_sync.sv
// bit_sync
// N-stage synchroniser for an asynchronous single-bit input. Flops reset to 1
// so an idle-high line shows no spurious low during reset release.
//   clk : destination clock
//   rst : asynchronous active-low reset
//   d   : asynchronous input
//   q   : synchronised output (d itself when N = 0)
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (N == 0) begin : g_bypass
    logic sync_unused;
    assign sync_unused = clk & rst;
    assign q = d;
  end else begin : g_sync
    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < N; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= sync_d;
    end

    assign q = sync_q[N-1];
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Oversampling timing and bit recovery for the UART receiver. Counts edges
// within a bit and completed bit periods, captures three mid-bit samples of
// the synchronised line and majority-votes them into one recovered bit.
//   clk_RX  : oversampling clock
//   rst     : asynchronous active-low reset
//   rx_if   : slave modport carrying RX_IN, Prescale, edge_cnt_enable,
//             dat_samp_en in and edge_cnt, bit_cnt, edge_cnt_max,
//             sampled_bit, take_sample, str_glitch out
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BIT_CNT_MAX = 11
) (
  input  logic                clk_RX,
  input  logic                rst,
  uart_rx_sampler_if.slave    rx_if
);

  localparam bit_cnt_t BIT_MAX = bit_cnt_t'(BIT_CNT_MAX);

  logic      rx_s;
  edge_cnt_t p_eff;
  edge_cnt_t half;

  edge_cnt_t edge_cnt_q, edge_cnt_d;
  bit_cnt_t  bit_cnt_q, bit_cnt_d;
  logic [2:0] samp_q, samp_d;
  logic [2:0] samp_vld_q, samp_vld_d;
  logic      sampled_bit_q, sampled_bit_d;
  logic      str_glitch_q, str_glitch_d;

  logic      enable;
  logic      sample_act;
  logic      wrap;
  logic      vote;
  logic      vote_now;

  bit_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk_RX),
    .rst (rst),
    .d   (rx_if.RX_IN),
    .q   (rx_s)
  );

  assign p_eff      = eff_prescale(rx_if.Prescale);
  assign half       = p_eff >> 1;
  assign enable     = rx_if.edge_cnt_enable;
  assign sample_act = enable & rx_if.dat_samp_en;

  // Wrapping at 63 covers an illegal mid-frame prescale shrink: the counter
  // overruns the new P-1 and must still come back to 0.
  always_comb begin
    wrap       = enable && ((edge_cnt_q == p_eff - 6'd1) || (edge_cnt_q == 6'd63));
    edge_cnt_d = edge_cnt_q + 6'd1;
    bit_cnt_d  = bit_cnt_q;
    if (!enable) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (wrap) begin
      edge_cnt_d = '0;
      if (bit_cnt_q != BIT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  // Valid flags chain s0 -> s1 -> s2 so that only an unbroken set of three
  // captures from the current bit can be voted.
  always_comb begin
    samp_d     = samp_q;
    samp_vld_d = samp_vld_q;
    vote       = majority3(samp_q[0], samp_q[1], samp_q[2]);
    vote_now   = sample_act && (edge_cnt_q == half + 6'd2) && (&samp_vld_q);
    if (!sample_act) begin
      samp_vld_d = '0;
    end else if (edge_cnt_q == half - 6'd1) begin
      samp_d[0]  = rx_s;
      samp_vld_d = 3'b001;
    end else if (edge_cnt_q == half) begin
      samp_d[1]     = rx_s;
      samp_vld_d[1] = samp_vld_q[0];
    end else if (edge_cnt_q == half + 6'd1) begin
      samp_d[2]     = rx_s;
      samp_vld_d[2] = samp_vld_q[1];
    end else if (edge_cnt_q == half + 6'd2) begin
      samp_vld_d = '0;
    end
  end

  // Glitch flag is decided only by the start-bit vote and then held so the
  // FSM can still inspect it once bit_cnt has moved on to 1.
  always_comb begin
    sampled_bit_d = vote_now ? vote : sampled_bit_q;
    str_glitch_d  = str_glitch_q;
    if (!enable)                            str_glitch_d = 1'b0;
    else if (vote_now && bit_cnt_q == '0)   str_glitch_d = vote;
  end

  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      samp_q        <= '1;
      samp_vld_q    <= '0;
      sampled_bit_q <= 1'b1;
      str_glitch_q  <= 1'b0;
    end else begin
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      samp_q        <= samp_d;
      samp_vld_q    <= samp_vld_d;
      sampled_bit_q <= sampled_bit_d;
      str_glitch_q  <= str_glitch_d;
    end
  end

  assign rx_if.edge_cnt     = edge_cnt_q;
  assign rx_if.bit_cnt      = bit_cnt_q;
  assign rx_if.edge_cnt_max = enable && (edge_cnt_q == p_eff - 6'd1);
  assign rx_if.sampled_bit  = sampled_bit_q;
  assign rx_if.take_sample  = vote_now;
  assign rx_if.str_glitch   = str_glitch_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
// Scoreboard bench for uart_rx_sampler. Each frame is described as the level
// of the synchronised line per cycle plus a per-cycle dat_samp_en; the bench
// derives the expected votes from bit positions and majority arithmetic,
// queues them, and a monitor compares them whenever take_sample fires.
module tb_uart_rx_sampler;

  localparam int SYNC    = 2;
  localparam int BMAX    = 11;
  localparam int MAXC    = 512;

  typedef struct {
    int edge_idx;
    int bitc;
    bit vote;
    bit gl;
  } exp_t;

  logic clk_RX = 1'b0;
  logic rst;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler #(.SYNC_STAGES(SYNC), .BIT_CNT_MAX(BMAX)) dut (
    .clk_RX (clk_RX),
    .rst    (rst),
    .rx_if  (rx_if)
  );

  always #5 clk_RX = ~clk_RX;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb_q[$];
  bit   line_s[MAXC];
  bit   dat_a[MAXC];
  bit   exp_sb = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_edge_cnt", rx_if.edge_cnt, 0);
    checkOutput("rst_bit_cnt", rx_if.bit_cnt, 0);
    checkOutput("rst_edge_cnt_max", rx_if.edge_cnt_max, 0);
    checkOutput("rst_sampled_bit", rx_if.sampled_bit, 1);
    checkOutput("rst_take_sample", rx_if.take_sample, 0);
    checkOutput("rst_str_glitch", rx_if.str_glitch, 0);
  endtask

  // Random line: one random level per bit period of length pe, with
  // occasional single-cycle flips to exercise the majority vote.
  task automatic fillRandom(input int pe);
    bit base;
    for (int c = 0; c < MAXC; c++) begin
      if (c % pe == 0) base = 1'($urandom % 2);
      line_s[c] = base ^ ($urandom % 6 == 0);
      dat_a[c]  = 1'b1;
    end
  endtask

  // Runs one frame of ncyc enabled cycles, then either drops the enable or
  // asserts reset in cycle ncyc.
  task automatic applyStimulus(input int p_in, input int ncyc, input bit end_rst);
    int   pe, h, nb, strobe, k;
    bit   cm[64];
    bit   vt[64];
    bit   gl, sb, ts;
    exp_t e;

    pe = (p_in == 16 || p_in == 32) ? p_in : 8;
    h  = pe / 2;
    nb = ncyc / pe + 1;
    gl = 1'b0;
    for (k = 0; k < nb; k++) begin
      strobe = k * pe + h + 2;
      vt[k]  = (int'(line_s[k*pe+h-1]) + int'(line_s[k*pe+h]) + int'(line_s[k*pe+h+1])) >= 2;
      cm[k]  = strobe < ncyc;
      for (int c = k * pe + h - 1; c <= strobe; c++) if (!dat_a[c]) cm[k] = 1'b0;
      if (cm[k]) begin
        if (k == 0) gl = vt[k];
        e.edge_idx = h + 2;
        e.bitc     = (k > BMAX) ? BMAX : k;
        e.vote     = vt[k];
        e.gl       = gl;
        sb_q.push_back(e);
      end
    end

    for (int i = 0; i < SYNC; i++) begin
      @(posedge clk_RX); #1;
      rx_if.edge_cnt_enable = 1'b0;
      rx_if.dat_samp_en     = 1'b0;
      rx_if.Prescale        = 6'(p_in);
      rx_if.RX_IN           = line_s[i];
    end

    gl = 1'b0;
    sb = exp_sb;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_RX); #1;
      rx_if.edge_cnt_enable = 1'b1;
      rx_if.dat_samp_en     = dat_a[c];
      rx_if.RX_IN           = line_s[c+SYNC];
      @(negedge clk_RX);
      k  = c / pe;
      ts = cm[k] && (c == k * pe + h + 2);
      checkOutput("edge_cnt", rx_if.edge_cnt, c % pe);
      checkOutput("bit_cnt", rx_if.bit_cnt, (k > BMAX) ? BMAX : k);
      checkOutput("edge_cnt_max", rx_if.edge_cnt_max, (c % pe == pe - 1));
      checkOutput("take_sample", rx_if.take_sample, ts);
      checkOutput("sampled_bit_level", rx_if.sampled_bit, sb);
      checkOutput("str_glitch_level", rx_if.str_glitch, gl);
      if (ts) begin
        sb = vt[k];
        if (k == 0) gl = vt[k];
      end
    end

    @(posedge clk_RX); #1;
    rx_if.edge_cnt_enable = 1'b0;
    rx_if.dat_samp_en     = 1'b0;
    if (end_rst) begin
      rst = 1'b0;
      @(negedge clk_RX);
      checkReset();
      @(posedge clk_RX); #1;
      rst = 1'b1;
      exp_sb = 1'b1;
    end else begin
      @(negedge clk_RX);
      checkOutput("drop_edge_cnt_max", rx_if.edge_cnt_max, 0);
      checkOutput("drop_take_sample", rx_if.take_sample, 0);
      @(negedge clk_RX);
      checkOutput("drop_edge_cnt", rx_if.edge_cnt, 0);
      checkOutput("drop_bit_cnt", rx_if.bit_cnt, 0);
      checkOutput("drop_str_glitch", rx_if.str_glitch, 0);
      checkOutput("drop_sampled_hold", rx_if.sampled_bit, sb);
      exp_sb = sb;
    end
  endtask

  // Monitor: pops one expectation per strobe; the recovered bit and glitch
  // flag are checked on the cycle after the strobe, once registered.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_RX);
      if (rx_if.take_sample === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_strobe: take_sample 1 with empty queue at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          checkOutput("strobe_edge", rx_if.edge_cnt, e.edge_idx);
          checkOutput("strobe_bit_cnt", rx_if.bit_cnt, e.bitc);
          @(negedge clk_RX);
          checkOutput("vote", rx_if.sampled_bit, e.vote);
          checkOutput("glitch_after_vote", rx_if.str_glitch, e.gl);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pl[6] = '{8, 16, 32, 20, 0, 63};
    int p, pe, ncyc, st;
    bit er;

    rst                   = 1'b0;
    rx_if.RX_IN           = 1'b1;
    rx_if.Prescale        = 6'd8;
    rx_if.edge_cnt_enable = 1'b0;
    rx_if.dat_samp_en     = 1'b0;
    repeat (2) @(posedge clk_RX);
    @(negedge clk_RX);
    checkReset();
    @(posedge clk_RX); #1;
    rst = 1'b1;

    $display("[TB] P=8 alternating bits, bit_cnt saturation");
    for (int c = 0; c < MAXC; c++) begin
      line_s[c] = (c / 8 == 0) ? 1'b0 : 1'((c / 8) % 2);
      dat_a[c]  = 1'b1;
    end
    applyStimulus(8, 112, 1'b0);

    $display("[TB] P=16 short start bit");
    fillRandom(16);
    for (int c = 0; c < 16; c++) line_s[c] = (c >= 7);
    applyStimulus(16, 48, 1'b0);

    $display("[TB] P=32 one-edge glitch in a zero bit");
    fillRandom(32);
    for (int c = 0; c < 32; c++) line_s[c] = (c == 16);
    applyStimulus(32, 64, 1'b0);

    $display("[TB] P=8 dat_samp_en drop at edge 4");
    fillRandom(8);
    for (int c = 20; c < 24; c++) dat_a[c] = 1'b0;
    applyStimulus(8, 40, 1'b0);

    $display("[TB] P=8 enable drop at edge 5 after glitch start");
    fillRandom(8);
    for (int c = 0; c < 8; c++) line_s[c] = 1'b1;
    applyStimulus(8, 21, 1'b0);

    $display("[TB] Prescale=20 reset at bit 5 edge 6");
    fillRandom(8);
    applyStimulus(20, 46, 1'b1);

    for (int i = 0; i < 6; i++) begin
      p    = pl[$urandom_range(0, 5)];
      pe   = (p == 16 || p == 32) ? p : 8;
      ncyc = $urandom_range(2 * pe, 13 * pe);
      er   = ($urandom % 4 == 0);
      if (er && (ncyc % pe == pe / 2 + 3)) ncyc++;
      fillRandom(pe);
      if ($urandom % 2 == 1) begin
        st = $urandom_range(0, ncyc - 1);
        for (int j = 0; j < 4; j++) dat_a[st+j] = 1'b0;
      end
      $display("[TB] random frame %0d: Prescale=%0d cycles=%0d reset_end=%0d", i, p, ncyc, er);
      applyStimulus(p, ncyc, er);
    end

    repeat (4) @(posedge clk_RX);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL missing_strobes: %0d queued votes left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
